// File: rtl/i2c_pkg.sv
// i2c_pkg
//   Shared definitions for the I2C register-access front end: engine command
//   bit positions and encodings, completion status codes and the sequencer
//   state encoding.
package i2c_pkg;

    // Engine command word layout {Start, R_nW, Ack, Stop}
    localparam int unsigned CMD_START_BIT = 3;
    localparam int unsigned CMD_RNW_BIT   = 2;
    localparam int unsigned CMD_ACK_BIT   = 1;
    localparam int unsigned CMD_STOP_BIT  = 0;

    localparam logic [3:0] CMD_START_WR       = 4'b1000;
    localparam logic [3:0] CMD_DATA           = 4'b0000;
    localparam logic [3:0] CMD_DATA_STOP      = 4'b0001;
    localparam logic [3:0] CMD_READ_NACK_STOP = 4'b0101;
    localparam logic [3:0] CMD_NONE           = 4'b0000;

    localparam logic [7:0] TX_IDLE = 8'hFF;

    typedef enum logic [1:0] {
        ST_OK        = 2'b00,
        ST_ADDR_NACK = 2'b01,
        ST_DATA_NACK = 2'b10,
        ST_TIMEOUT   = 2'b11
    } status_e;

    typedef enum logic [2:0] {
        sIdle,
        sLoad,
        sWaitBusy,
        sWaitDone,
        sCheck,
        sDone
    } state_e;

endpackage

// File: rtl/i2c_register_access_if.sv
// i2c_register_access_if
//   Groups the request/response handshake (user side) and the byte-engine
//   handshake (engine side) of i2c_register_access.
//   slave  : used by i2c_register_access
//   master : used by whatever drives requests and models the engine
//   User side  : ipValid, opReady, ipWrite, ipDevice, ipRegister, ipWrData,
//                opDone, opStatus, opRdData
//   Engine side: opTxData, opCommand, opGo, ipBusy, ipError, ipRxData
interface i2c_register_access_if;

    logic       ipValid;
    logic       opReady;
    logic       ipWrite;
    logic [6:0] ipDevice;
    logic [7:0] ipRegister;
    logic [7:0] ipWrData;
    logic       opDone;
    logic [1:0] opStatus;
    logic [7:0] opRdData;

    logic [7:0] opTxData;
    logic [3:0] opCommand;
    logic       opGo;
    logic       ipBusy;
    logic       ipError;
    logic [7:0] ipRxData;

    modport slave (
        input  ipValid, ipWrite, ipDevice, ipRegister, ipWrData,
        input  ipBusy, ipError, ipRxData,
        output opReady, opDone, opStatus, opRdData,
        output opTxData, opCommand, opGo
    );

    modport master (
        output ipValid, ipWrite, ipDevice, ipRegister, ipWrData,
        output ipBusy, ipError, ipRxData,
        input  opReady, opDone, opStatus, opRdData,
        input  opTxData, opCommand, opGo
    );

endinterface

// File: rtl/i2c_register_access.sv
// i2c_register_access
//   Turns one register request into the 3-byte write or 4-byte read sequence
//   for the I2C byte engine, runs the per-byte Go/Busy 4-phase handshake,
//   and reports completion with a status code and (for reads) the data byte.
//   Ports:
//     ipClk     clock
//     ipnReset  asynchronous active-low reset
//     bus       i2c_register_access_if.slave (user request + engine handshake)
//   Parameter:
//     Timeout_Cycles  max cycles spent waiting on one byte before abort
module i2c_register_access
    import i2c_pkg::*;
#(
    parameter int unsigned Timeout_Cycles = 1_000_000
) (
    input logic                   ipClk,
    input logic                   ipnReset,
    i2c_register_access_if.slave  bus
);

    localparam int unsigned TMO_W = (Timeout_Cycles > 1) ? $clog2(Timeout_Cycles) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(Timeout_Cycles - 1);

    state_e           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    status_e          status_q, status_d;
    logic [7:0]       rd_q, rd_d;

    // Latched request
    logic             wr_q, wr_d;
    logic [6:0]       dev_q, dev_d;
    logic [7:0]       reg_q, reg_d;
    logic [7:0]       wdat_q, wdat_d;

    logic [7:0]       tx_byte;
    logic [3:0]       tx_cmd;
    logic [1:0]       last_idx;
    logic             byte_written;
    logic             go;
    logic             done;
    logic             in_xfer;

    // Byte sequencing table, indexed by the current byte number
    always_comb begin
        tx_byte = TX_IDLE;
        tx_cmd  = CMD_READ_NACK_STOP;
        case (idx_q)
            2'd0: begin
                tx_byte = {dev_q, 1'b0};
                tx_cmd  = CMD_START_WR;
            end
            2'd1: begin
                tx_byte = reg_q;
                tx_cmd  = CMD_DATA;
            end
            2'd2: begin
                if (wr_q) begin
                    tx_byte = wdat_q;
                    tx_cmd  = CMD_DATA_STOP;
                end else begin
                    tx_byte = {dev_q, 1'b1};
                    tx_cmd  = CMD_START_WR;
                end
            end
            default: begin
                tx_byte = TX_IDLE;
                tx_cmd  = CMD_READ_NACK_STOP;
            end
        endcase
    end

    assign last_idx     = wr_q ? 2'd2 : 2'd3;
    // The final read byte is received, so an engine error there is not a NACK
    assign byte_written = wr_q || (idx_q != 2'd3);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        tmo_d    = tmo_q;
        status_d = status_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        dev_d    = dev_q;
        reg_d    = reg_q;
        wdat_d   = wdat_q;
        go       = 1'b0;
        done     = 1'b0;

        case (state_q)
            sIdle: begin
                if (bus.ipValid) begin
                    wr_d    = bus.ipWrite;
                    dev_d   = bus.ipDevice;
                    reg_d   = bus.ipRegister;
                    wdat_d  = bus.ipWrData;
                    idx_d   = 2'd0;
                    state_d = sLoad;
                end
            end
            sLoad: begin
                go      = 1'b1;
                tmo_d   = '0;
                state_d = sWaitBusy;
            end
            sWaitBusy: begin
                if (tmo_q == TMO_LAST) begin
                    status_d = ST_TIMEOUT;
                    state_d  = sDone;
                end else begin
                    go    = 1'b1;
                    tmo_d = tmo_q + 1'b1;
                    if (bus.ipBusy) begin
                        state_d = sWaitDone;
                    end
                end
            end
            sWaitDone: begin
                if (tmo_q == TMO_LAST) begin
                    status_d = ST_TIMEOUT;
                    state_d  = sDone;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                    if (!bus.ipBusy) begin
                        state_d = sCheck;
                    end
                end
            end
            sCheck: begin
                if (bus.ipError && byte_written) begin
                    // Byte 2 is the data byte on a write but the repeated
                    // device address on a read
                    if (idx_q == 2'd0 || (idx_q == 2'd2 && !wr_q)) begin
                        status_d = ST_ADDR_NACK;
                    end else begin
                        status_d = ST_DATA_NACK;
                    end
                    state_d = sDone;
                end else if (idx_q == last_idx) begin
                    status_d = ST_OK;
                    if (!wr_q) begin
                        rd_d = bus.ipRxData;
                    end
                    state_d = sDone;
                end else begin
                    idx_d   = idx_q + 2'd1;
                    state_d = sLoad;
                end
            end
            sDone: begin
                done    = 1'b1;
                state_d = sIdle;
            end
            default: begin
                state_d = sIdle;
            end
        endcase
    end

    always_ff @(posedge ipClk or negedge ipnReset) begin
        if (!ipnReset) begin
            state_q  <= sIdle;
            idx_q    <= '0;
            tmo_q    <= '0;
            status_q <= ST_OK;
            rd_q     <= '0;
            wr_q     <= 1'b0;
            dev_q    <= '0;
            reg_q    <= '0;
            wdat_q   <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            tmo_q    <= tmo_d;
            status_q <= status_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            dev_q    <= dev_d;
            reg_q    <= reg_d;
            wdat_q   <= wdat_d;
        end
    end

    // TxData/Command derive from latched registers only, so they stay
    // stable from sLoad through sCheck
    assign in_xfer = (state_q == sLoad) || (state_q == sWaitBusy) ||
                     (state_q == sWaitDone) || (state_q == sCheck);

    assign bus.opReady   = (state_q == sIdle);
    assign bus.opDone    = done;
    assign bus.opStatus  = status_q;
    assign bus.opRdData  = rd_q;
    assign bus.opGo      = go;
    assign bus.opTxData  = in_xfer ? tx_byte : TX_IDLE;
    assign bus.opCommand = in_xfer ? tx_cmd : CMD_NONE;

endmodule

// File: tb/tb_i2c_register_access.sv
// tb_i2c_register_access
//   Directed bench for i2c_register_access with a behavioural byte engine
//   that follows the Go/Busy 4-phase handshake and logs each issued byte.
module tb_i2c_register_access;

    logic clk;
    logic rst_n;

    i2c_register_access_if bus();

    i2c_register_access #(.Timeout_Cycles(100)) dut (
        .ipClk   (clk),
        .ipnReset(rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Engine model controls and byte log ({TxData, Command})
    logic [11:0] log_q[$];
    int          eng_err_idx;
    logic [7:0]  eng_rx;
    logic        eng_hang;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Behavioural byte engine
    initial begin
        int bi;
        bus.ipBusy   = 1'b0;
        bus.ipError  = 1'b0;
        bus.ipRxData = 8'h00;
        forever begin
            @(posedge clk); #1;
            if (bus.opGo && !bus.ipBusy) begin
                bi = log_q.size();
                log_q.push_back({bus.opTxData, bus.opCommand});
                bus.ipError = 1'b0;
                repeat (2) @(posedge clk);
                #1 bus.ipBusy = 1'b1;
                while (eng_hang) begin @(posedge clk); #1; end
                while (bus.opGo) begin @(posedge clk); #1; end
                repeat (3) @(posedge clk);
                #1;
                bus.ipError  = (bi == eng_err_idx);
                bus.ipRxData = eng_rx;
                bus.ipBusy   = 1'b0;
            end
        end
    end

    // Hard stop in case something never returns
    initial begin
        #400_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic start_req(input logic w, input logic [6:0] dev, input logic [7:0] rg,
                             input logic [7:0] wd, output bit accepted);
        logic rdy;
        accepted        = 1'b0;
        bus.ipValid     = 1'b1;
        bus.ipWrite     = w;
        bus.ipDevice    = dev;
        bus.ipRegister  = rg;
        bus.ipWrData    = wd;
        for (int unsigned i = 0; i < 200 && !accepted; i++) begin
            rdy = bus.opReady;
            @(posedge clk); #1;
            if (rdy) accepted = 1'b1;
        end
        // Scramble the request inputs: the DUT must use its latched copy
        bus.ipValid    = 1'b0;
        bus.ipWrite    = ~w;
        bus.ipDevice   = ~dev;
        bus.ipRegister = ~rg;
        bus.ipWrData   = ~wd;
        chk("accept", 32'(accepted), 32'd1);
    endtask

    task automatic wait_done(output bit got, output logic [1:0] st, output logic [7:0] rd,
                             output int cyc);
        got = 1'b0;
        st  = 2'b00;
        rd  = 8'h00;
        cyc = 0;
        for (int unsigned i = 1; i <= 400 && !got; i++) begin
            @(posedge clk); #1;
            if (bus.opDone) begin
                got = 1'b1;
                st  = bus.opStatus;
                rd  = bus.opRdData;
                cyc = int'(i);
            end
        end
        chk("done_seen", 32'(got), 32'd1);
    endtask

    task automatic wait_engine_idle();
        bit idle;
        idle = 1'b0;
        for (int unsigned i = 0; i < 200 && !idle; i++) begin
            @(posedge clk); #1;
            if (!bus.ipBusy) idle = 1'b1;
        end
        chk("engine_idle", 32'(idle), 32'd1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic             w;
        logic [6:0]       dev;
        logic [7:0]       rg;
        logic [7:0]       wd;
        int               err;
        logic [7:0]       rx;
        logic [1:0]       st;
        logic [7:0]       rd;
        int               n;
        logic [0:3][11:0] b;
    } vec_t;

    vec_t vecs[9];

    initial begin
        bit         acc, got, got2;
        logic [1:0] st, st2;
        logic [7:0] rd, rd2;
        int         cyc, ndone;
        logic       go_at_done;

        rst_n          = 1'b0;
        bus.ipValid    = 1'b0;
        bus.ipWrite    = 1'b0;
        bus.ipDevice   = 7'h00;
        bus.ipRegister = 8'h00;
        bus.ipWrData   = 8'h00;
        eng_hang       = 1'b0;
        eng_err_idx    = -1;
        eng_rx         = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready",  32'(bus.opReady),   32'd1);
        chk("rst_done",   32'(bus.opDone),    32'd0);
        chk("rst_status", 32'(bus.opStatus),  32'd0);
        chk("rst_rd",     32'(bus.opRdData),  32'h00);
        chk("rst_go",     32'(bus.opGo),      32'd0);
        chk("rst_tx",     32'(bus.opTxData),  32'hFF);
        chk("rst_cmd",    32'(bus.opCommand), 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        //           w     dev    reg    wd     err rx     st     rd     n   bytes
        vecs[0] = '{1'b1, 7'h50, 8'h10, 8'hA5, -1, 8'h00, 2'b00, 8'h00, 3, {12'hA08, 12'h100, 12'hA51, 12'h000}};
        vecs[1] = '{1'b0, 7'h50, 8'h20, 8'h00, -1, 8'h3C, 2'b00, 8'h3C, 4, {12'hA08, 12'h200, 12'hA18, 12'hFF5}};
        vecs[2] = '{1'b1, 7'h50, 8'h10, 8'hA5,  0, 8'h00, 2'b01, 8'h3C, 1, {12'hA08, 12'h000, 12'h000, 12'h000}};
        vecs[3] = '{1'b1, 7'h50, 8'h11, 8'h5A,  2, 8'h00, 2'b10, 8'h3C, 3, {12'hA08, 12'h110, 12'h5A1, 12'h000}};
        vecs[4] = '{1'b0, 7'h50, 8'h22, 8'h00,  2, 8'h00, 2'b01, 8'h3C, 3, {12'hA08, 12'h220, 12'hA18, 12'h000}};
        vecs[5] = '{1'b0, 7'h50, 8'h23, 8'h00,  1, 8'h00, 2'b10, 8'h3C, 2, {12'hA08, 12'h230, 12'h000, 12'h000}};
        vecs[6] = '{1'b1, 7'h7F, 8'hFF, 8'h00, -1, 8'h00, 2'b00, 8'h3C, 3, {12'hFE8, 12'hFF0, 12'h001, 12'h000}};
        vecs[7] = '{1'b0, 7'h01, 8'h00, 8'h00, -1, 8'h81, 2'b00, 8'h81, 4, {12'h028, 12'h000, 12'h038, 12'hFF5}};
        vecs[8] = '{1'b0, 7'h50, 8'h24, 8'h00,  3, 8'h55, 2'b00, 8'h55, 4, {12'hA08, 12'h240, 12'hA18, 12'hFF5}};

        for (int unsigned v = 0; v < 9; v++) begin
            log_q.delete();
            eng_err_idx = vecs[v].err;
            eng_rx      = vecs[v].rx;
            start_req(vecs[v].w, vecs[v].dev, vecs[v].rg, vecs[v].wd, acc);
            wait_done(got, st, rd, cyc);
            chk($sformatf("v%0d_status", v), 32'(st), 32'(vecs[v].st));
            chk($sformatf("v%0d_rd", v),     32'(rd), 32'(vecs[v].rd));
            @(posedge clk); #1;
            chk($sformatf("v%0d_ready", v),  32'(bus.opReady), 32'd1);
            chk($sformatf("v%0d_pulse", v),  32'(bus.opDone),  32'd0);
            wait_engine_idle();
            chk($sformatf("v%0d_nbytes", v), 32'(log_q.size()), 32'(vecs[v].n));
            for (int unsigned j = 0; j < 4; j++) begin
                if (int'(j) < vecs[v].n) begin
                    chk($sformatf("v%0d_byte%0d", v, j),
                        (int'(j) < log_q.size()) ? 32'(log_q[j]) : 32'hDEAD,
                        32'(vecs[v].b[j]));
                end
            end
        end
        eng_err_idx = -1;

        // Timeout: engine holds Busy high indefinitely
        log_q.delete();
        eng_hang = 1'b1;
        start_req(1'b1, 7'h50, 8'h10, 8'hA5, acc);
        wait_done(got, st, rd, cyc);
        go_at_done = bus.opGo;
        chk("tmo_status", 32'(st), 32'd3);
        chk("tmo_go_low", 32'(go_at_done), 32'd0);
        chk("tmo_latency_window", 32'(cyc >= 99 && cyc <= 103), 32'd1);
        chk("tmo_nbytes", 32'(log_q.size()), 32'd1);
        eng_hang = 1'b0;
        wait_engine_idle();

        // Reset during byte 1 of a read
        log_q.delete();
        eng_rx = 8'h66;
        start_req(1'b0, 7'h50, 8'h40, 8'h00, acc);
        got = 1'b0;
        for (int unsigned i = 0; i < 200 && !got; i++) begin
            @(posedge clk); #1;
            if (log_q.size() >= 2) got = 1'b1;
        end
        chk("mid_byte1_reached", 32'(got), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_ready",  32'(bus.opReady),   32'd1);
        chk("mid_rst_done",   32'(bus.opDone),    32'd0);
        chk("mid_rst_status", 32'(bus.opStatus),  32'd0);
        chk("mid_rst_rd",     32'(bus.opRdData),  32'h00);
        chk("mid_rst_go",     32'(bus.opGo),      32'd0);
        chk("mid_rst_tx",     32'(bus.opTxData),  32'hFF);
        chk("mid_rst_cmd",    32'(bus.opCommand), 32'h0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        ndone = 0;
        for (int unsigned i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (bus.opDone) ndone++;
        end
        chk("mid_rst_no_done", 32'(ndone), 32'd0);
        wait_engine_idle();

        // Request while busy is ignored
        log_q.delete();
        start_req(1'b1, 7'h50, 8'h30, 8'h77, acc);
        bus.ipValid    = 1'b1;
        bus.ipWrite    = 1'b0;
        bus.ipDevice   = 7'h33;
        bus.ipRegister = 8'h99;
        repeat (5) @(posedge clk);
        #1 bus.ipValid = 1'b0;
        wait_done(got, st, rd, cyc);
        chk("busy_ign_status", 32'(st), 32'd0);
        wait_engine_idle();
        repeat (10) @(posedge clk);
        #1;
        chk("busy_ign_nbytes", 32'(log_q.size()), 32'd3);
        chk("busy_ign_byte1", (log_q.size() > 1) ? 32'(log_q[1]) : 32'hDEAD, 32'h300);
        chk("busy_ign_byte2", (log_q.size() > 2) ? 32'(log_q[2]) : 32'hDEAD, 32'h771);

        // Back-to-back requests
        log_q.delete();
        eng_rx = 8'h9E;
        start_req(1'b1, 7'h12, 8'h34, 8'h56, acc);
        wait_done(got, st, rd, cyc);
        start_req(1'b0, 7'h12, 8'h78, 8'h00, acc);
        wait_done(got2, st2, rd2, cyc);
        chk("b2b_a_status", 32'(st),  32'd0);
        chk("b2b_b_status", 32'(st2), 32'd0);
        chk("b2b_b_rd",     32'(rd2), 32'h9E);
        wait_engine_idle();
        chk("b2b_nbytes", 32'(log_q.size()), 32'd7);
        chk("b2b_byte2", (log_q.size() > 2) ? 32'(log_q[2]) : 32'hDEAD, 32'h561);
        chk("b2b_byte4", (log_q.size() > 4) ? 32'(log_q[4]) : 32'hDEAD, 32'h780);
        chk("b2b_byte5", (log_q.size() > 5) ? 32'(log_q[5]) : 32'hDEAD, 32'h258);
        chk("b2b_byte6", (log_q.size() > 6) ? 32'(log_q[6]) : 32'hDEAD, 32'hFF5);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
